tour_cmd: RTL and testbench

TOUR_CMD -- requirements
Module: tour_cmd

---
 rtl/tour_pkg.sv | 31 +++
 rtl/tour_move_decode.sv | 55 +++++
 rtl/tour_cmd.sv | 135 +++++++++++++
 tb/tb_tour_cmd.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// Shared constants and FSM state type for the knight-tour command sequencer.
// Abort-on-UART behaviour is selected by the TOUR_CMD_ABORT_EN macro in tour_cmd.
package tour_pkg;

  localparam logic [3:0] OP_CAL     = 4'h0;
  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_FANFARE = 4'h3;

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;

  localparam logic [7:0] RESP_IDLE = 8'hA5;
  localparam logic [7:0] RESP_TOUR = 8'h5A;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    WAIT_V = 3'd2,
    HORZ   = 3'd3,
    WAIT_H = 3'd4
  } state_t;

  function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                         input logic [7:0] heading,
                                         input logic [3:0] squares);
    return {op, heading, squares};
  endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Maps a one-hot knight move to its vertical (N/S) and horizontal (E/W)
// motion commands; a non-one-hot move decodes to zero-square legs.
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

  // Decode move bit to (heading, squares) for each leg
  always_comb begin
    vert_cmd = mk_cmd(OP_MOVE, HEAD_N, 4'd0);
    horz_cmd = mk_cmd(OP_FANFARE, HEAD_E, 4'd0);
    case (move)
      8'h01: begin
        vert_cmd = mk_cmd(OP_MOVE, HEAD_N, 4'd2);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_E, 4'd1);
      end
      8'h02: begin
        vert_cmd = mk_cmd(OP_MOVE, HEAD_N, 4'd2);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_W, 4'd1);
      end
      8'h04: begin
        vert_cmd = mk_cmd(OP_MOVE, HEAD_N, 4'd1);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_W, 4'd2);
      end
      8'h08: begin
        vert_cmd = mk_cmd(OP_MOVE, HEAD_S, 4'd1);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_W, 4'd2);
      end
      8'h10: begin
        vert_cmd = mk_cmd(OP_MOVE, HEAD_S, 4'd2);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_W, 4'd1);
      end
      8'h20: begin
        vert_cmd = mk_cmd(OP_MOVE, HEAD_S, 4'd2);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_E, 4'd1);
      end
      8'h40: begin
        vert_cmd = mk_cmd(OP_MOVE, HEAD_S, 4'd1);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_E, 4'd2);
      end
      8'h80: begin
        vert_cmd = mk_cmd(OP_MOVE, HEAD_N, 4'd1);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_E, 4'd2);
      end
      default: begin
        vert_cmd = mk_cmd(OP_MOVE, HEAD_N, 4'd0);
        horz_cmd = mk_cmd(OP_FANFARE, HEAD_E, 4'd0);
      end
    endcase
  end

endmodule

// File: rtl/tour_cmd.sv
// Sequences a solved knight tour into two-leg motion commands, muxed with UART
// commands in IDLE. TOUR_CMD_ABORT_EN: a UART command during a WAIT aborts the tour.
module tour_cmd
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  state_t      state_r, next_s;
  logic [4:0]  mv_indx_r;
  logic [15:0] cmd_r;
  logic        cmd_rdy_r;
  logic [7:0]  resp_r;
  logic [15:0] vert_cmd_s, horz_cmd_s;
  logic        in_leg_s, in_wait_s, abort_s;

  tour_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd_s),
    .horz_cmd (horz_cmd_s)
  );

  assign in_leg_s  = (state_r == VERT)   || (state_r == HORZ);
  assign in_wait_s = (state_r == WAIT_V) || (state_r == WAIT_H);

`ifdef TOUR_CMD_ABORT_EN
  logic abort_r;

  // Remember a UART request seen while waiting; honoured at the next send_resp
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      abort_r <= 1'b0;
    end else if (state_r == IDLE) begin
      abort_r <= 1'b0;
    end else if (in_wait_s && cmd_rdy_UART) begin
      abort_r <= 1'b1;
    end else begin
      abort_r <= abort_r;
    end
  end

  assign abort_s = abort_r | (in_wait_s & cmd_rdy_UART);
`else
  assign abort_s = 1'b0;
`endif

  // Next-state logic; a clear is only accepted once cmd_rdy is actually up
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_tour) next_s = VERT;
        else            next_s = IDLE;
      end
      VERT: begin
        if (clr_cmd_rdy && cmd_rdy_r) next_s = WAIT_V;
        else                          next_s = VERT;
      end
      WAIT_V: begin
        if (send_resp) next_s = abort_s ? IDLE : HORZ;
        else           next_s = WAIT_V;
      end
      HORZ: begin
        if (clr_cmd_rdy && cmd_rdy_r) next_s = WAIT_H;
        else                          next_s = HORZ;
      end
      WAIT_H: begin
        if (send_resp) begin
          if (abort_s || (mv_indx_r == LAST_IDX)) next_s = IDLE;
          else                                    next_s = VERT;
        end else begin
          next_s = WAIT_H;
        end
      end
      default: next_s = IDLE;
    endcase
  end

  // State, move index, registered command handshake and response byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      mv_indx_r <= 5'd0;
      cmd_r     <= 16'h0000;
      cmd_rdy_r <= 1'b0;
      resp_r    <= RESP_IDLE;
    end else begin
      state_r   <= next_s;
      cmd_rdy_r <= in_leg_s && !(clr_cmd_rdy && cmd_rdy_r);
      // cmd is captured only while cmd_rdy is low so it stays stable once offered
      if (!cmd_rdy_r && (state_r == VERT))      cmd_r <= vert_cmd_s;
      else if (!cmd_rdy_r && (state_r == HORZ)) cmd_r <= horz_cmd_s;
      else                                      cmd_r <= cmd_r;
      if ((state_r == IDLE) && start_tour)           mv_indx_r <= 5'd0;
      else if ((state_r == WAIT_H) && (next_s == VERT)) mv_indx_r <= mv_indx_r + 5'd1;
      else                                           mv_indx_r <= mv_indx_r;
      if (next_s == IDLE)              resp_r <= RESP_IDLE;
      else if (in_wait_s && send_resp) resp_r <= RESP_TOUR;
      else                             resp_r <= resp_r;
    end
  end

  // IDLE forwards the UART channel; otherwise the tour owns the command port
  always_comb begin
    if (state_r == IDLE) begin
      cmd              = cmd_UART;
      cmd_rdy          = cmd_rdy_UART;
      clr_cmd_rdy_UART = clr_cmd_rdy;
    end else begin
      cmd              = cmd_r;
      cmd_rdy          = cmd_rdy_r;
      clr_cmd_rdy_UART = 1'b0;
    end
  end

  assign mv_indx = mv_indx_r;
  assign resp    = resp_r;

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd: random tours checked against a
// (dx,dy) arithmetic model of the knight moves.
module tb_tour_cmd;

  localparam int NUM_MOVES = 24;
  localparam int DX [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  localparam int DY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tour = 1'b0;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h0000;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp;

  logic [7:0]  tour_mem [0:31];
  int errors = 0;
  int checks = 0;
  int cmds_seen = 0;

  assign move = tour_mem[mv_indx];

  tour_cmd #(.NUM_MOVES(NUM_MOVES)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  always #10 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: opcode/heading/squares derived from the signed displacement
  function automatic logic [15:0] leg_cmd(input logic [7:0] mv, input bit vertical);
    int k;
    int d;
    logic [3:0] op;
    logic [7:0] hd;
    k = 0;
    for (int i = 0; i < 8; i++) if (mv[i]) k = i;
    if (vertical) begin
      d  = DY[k];
      op = 4'h2;
      hd = (d > 0) ? 8'h00 : 8'h7F;
    end else begin
      d  = DX[k];
      op = 4'h3;
      hd = (d > 0) ? 8'hBF : 8'h3F;
    end
    if (d < 0) d = -d;
    return {op, hd, 4'(d)};
  endfunction

  task automatic randomize_tour();
    for (int i = 0; i < 32; i++) tour_mem[i] = 8'h01 << $urandom_range(0, 7);
  endtask

  task automatic do_leg(input logic [15:0] exp_cmd, input int exp_idx,
                        input logic [7:0] exp_resp, input bit noisy,
                        input bit hold, output bit ok);
    bit got;
    got = 1'b0;
    ok  = 1'b0;
    for (int t = 0; t < 16; t++) begin
      if (cmd_rdy === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL leg_timeout idx=%0d cmd_rdy=%b expected 1", exp_idx, cmd_rdy);
      return;
    end
    checks++;
    if (cmd !== exp_cmd) begin
      errors++;
      $display("FAIL leg_cmd idx=%0d got=%h expected=%h", exp_idx, cmd, exp_cmd);
    end
    checks++;
    if (mv_indx !== 5'(exp_idx)) begin
      errors++;
      $display("FAIL mv_indx got=%0d expected=%0d", mv_indx, exp_idx);
    end
    repeat ($urandom_range(0, 2)) begin
      tick();
      checks++;
      if (cmd_rdy !== 1'b1 || cmd !== exp_cmd) begin
        errors++;
        $display("FAIL cmd_hold idx=%0d got=%b/%h expected=1/%h", exp_idx, cmd_rdy, cmd, exp_cmd);
      end
    end
    clr_cmd_rdy = 1'b1;
    send_resp   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL cmd_rdy_drop idx=%0d got=%b expected=0", exp_idx, cmd_rdy);
    end
    ok = 1'b1;
    if (hold) return;
    repeat ($urandom_range(0, 2)) tick();
    if (noisy) begin
      start_tour = 1'b1;
      tick();
      start_tour = 1'b0;
      checks++;
      if (mv_indx !== 5'(exp_idx) || cmd_rdy !== 1'b0) begin
        errors++;
        $display("FAIL start_ignored got idx=%0d rdy=%b expected idx=%0d rdy=0", mv_indx, cmd_rdy, exp_idx);
      end
    end
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    checks++;
    if (resp !== exp_resp) begin
      errors++;
      $display("FAIL resp idx=%0d got=%h expected=%h", exp_idx, resp, exp_resp);
    end
  endtask

  task automatic drive_tour(input int stop_idx, input bit noisy);
    bit ok;
    bit last;
    cmds_seen  = 0;
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    for (int m = 0; m < NUM_MOVES; m++) begin
      for (int leg = 0; leg < 2; leg++) begin
        last = (m == NUM_MOVES - 1) && (leg == 1);
        do_leg(leg_cmd(tour_mem[m], leg == 0), m, last ? 8'hA5 : 8'h5A,
               noisy, (m == stop_idx) && (leg == 1), ok);
        if (!ok) return;
        cmds_seen++;
        if ((m == stop_idx) && (leg == 1)) return;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    logic [15:0] v;
    v = 16'($urandom);
    cmd_UART = v;
    cmd_rdy_UART = 1'b1;
    #1;
    checks++;
    if (cmd !== v || cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle_pass got=%h/%b expected=%h/1", tag, cmd, cmd_rdy, v);
    end
    cmd_rdy_UART = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (mv_indx !== 5'd0 || resp !== 8'hA5 || cmd_rdy !== 1'b0 || clr_cmd_rdy_UART !== 1'b0) begin
      errors++;
      $display("FAIL reset got idx=%0d resp=%h rdy=%b clr=%b expected 0/a5/0/0",
               mv_indx, resp, cmd_rdy, clr_cmd_rdy_UART);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    logic [15:0] v;
    logic r, c;
    cmd_UART = 16'h2001;
    cmd_rdy_UART = 1'b1;
    clr_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (cmd !== 16'h2001 || cmd_rdy !== 1'b1 || clr_cmd_rdy_UART !== 1'b1) begin
      errors++;
      $display("FAIL uart_pass got=%h/%b/%b expected=2001/1/1", cmd, cmd_rdy, clr_cmd_rdy_UART);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      v = 16'($urandom);
      r = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      cmd_UART = v;
      cmd_rdy_UART = r;
      clr_cmd_rdy = c;
      #1;
      checks++;
      if (cmd !== v || cmd_rdy !== r || clr_cmd_rdy_UART !== c || resp !== 8'hA5) begin
        errors++;
        $display("FAIL uart_pass_rand got=%h/%b/%b/%h expected=%h/%b/%b/a5",
                 cmd, cmd_rdy, clr_cmd_rdy_UART, resp, v, r, c);
      end
    end
    cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    bit ok;
    randomize_tour();
    tour_mem[0] = 8'h01;
    tour_mem[1] = 8'h08;
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    do_leg(16'h2002, 0, 8'h5A, 1'b0, 1'b0, ok);
    do_leg(16'h3BF1, 0, 8'h5A, 1'b0, 1'b0, ok);
    do_leg(16'h27F1, 1, 8'h5A, 1'b0, 1'b0, ok);
    do_leg(16'h33F2, 1, 8'h5A, 1'b0, 1'b0, ok);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_tour(input bit noisy);
    randomize_tour();
    drive_tour(-1, noisy);
    checks++;
    if (cmds_seen != 2 * NUM_MOVES || mv_indx !== 5'(NUM_MOVES - 1)) begin
      errors++;
      $display("FAIL full_tour got cmds=%0d idx=%0d expected cmds=%0d idx=%0d",
               cmds_seen, mv_indx, 2 * NUM_MOVES, NUM_MOVES - 1);
    end
    check_idle("full_tour");
  endtask

  task automatic test_reset_mid_tour();
    randomize_tour();
    drive_tour(7, 1'b0);
    checks++;
    if (mv_indx !== 5'd7) begin
      errors++;
      $display("FAIL mid_tour_idx got=%0d expected=7", mv_indx);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (mv_indx !== 5'd0 || cmd_rdy !== 1'b0 || resp !== 8'hA5) begin
      errors++;
      $display("FAIL mid_tour_reset got idx=%0d rdy=%b resp=%h expected 0/0/a5", mv_indx, cmd_rdy, resp);
    end
    rst_n = 1'b1;
    tick();
    check_idle("mid_reset");
  endtask

  task automatic test_uart_pending();
    bit ok;
    logic [15:0] v;
    randomize_tour();
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0;
    do_leg(leg_cmd(tour_mem[0], 1'b1), 0, 8'h5A, 1'b0, 1'b1, ok);
    v = 16'($urandom);
    cmd_UART = v;
    cmd_rdy_UART = 1'b1;
    clr_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (clr_cmd_rdy_UART !== 1'b0 || cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL uart_blocked got clr=%b rdy=%b expected 0/0", clr_cmd_rdy_UART, cmd_rdy);
    end
    tick();
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    #1;
`ifdef TOUR_CMD_ABORT_EN
    checks++;
    if (cmd !== v || cmd_rdy !== 1'b1 || resp !== 8'hA5) begin
      errors++;
      $display("FAIL abort got=%h/%b/%h expected=%h/1/a5", cmd, cmd_rdy, resp, v);
    end
`else
    do_leg(leg_cmd(tour_mem[0], 1'b0), 0, 8'h5A, 1'b0, 1'b1, ok);
    checks++;
    if (clr_cmd_rdy_UART !== 1'b0 || mv_indx !== 5'd0) begin
      errors++;
      $display("FAIL tour_continues got clr=%b idx=%0d expected 0/0", clr_cmd_rdy_UART, mv_indx);
    end
`endif
    cmd_rdy_UART = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tour_mem[i] = 8'h01;
    test_reset();
    test_passthrough();
    test_directed();
    test_full_tour(1'b0);
    test_full_tour(1'b1);
    test_reset_mid_tour();
    test_uart_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
